mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand width of the shared signed multiplier.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter MULT_LATENCY, default 6, cycles from operands on m_a/m_b to the product on m_c (2..16).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester operand-valid.
REQ-007 SHALL have port req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-008 SHALL have port req_a / req_b  input  NUM_REQ*DATA_WIDTH each  packed signed operands; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port m_a / m_b  output  DATA_WIDTH each  registered operands to the multiplier.
REQ-010 SHALL have port m_c  input  2*DATA_WIDTH  multiplier product.
REQ-011 SHALL have port rsp_valid  output  NUM_REQ  one-hot product-valid; no backpressure.
REQ-012 SHALL have port rsp_c  output  2*DATA_WIDTH  product, m_c passed through.
REQ-013 SHALL have port drain_req  input  1  level; stop granting and empty the pipeline.
REQ-014 SHALL have port drained  output  1  high while in DRAINED state.
REQ-015 SHALL have port busy  output  1  high while any product is in flight.

Function
REQ-016 SHALL grant combinationally: req_ready[i]=1 only if req_valid[i]=1, state is RUN, and i wins arbitration; a transfer is req_valid[i]&&req_ready[i].
REQ-017 SHALL register the granted operands into m_a/m_b on the transfer edge; m_a/m_b hold their value when no transfer occurs.
REQ-018 SHALL carry a valid bit and requester index through a MULT_LATENCY-deep shift register aligned with the multiplier pipeline.
REQ-019 SHALL drive rsp_valid one-hot for the tagged requester exactly 1+MULT_LATENCY cycles after the transfer cycle, with rsp_c=m_c in that cycle; no products dropped, reordered or duplicated.
REQ-020 SHALL sustain one transfer per cycle; back-to-back grants never stall.
REQ-021 SHALL keep an in-flight counter 0..MULT_LATENCY+1, incremented on transfer, decremented on rsp_valid; simultaneous increment and decrement leave it unchanged; busy=(counter!=0).
REQ-022 SHALL implement states RUN, DRAIN, DRAINED: RUN->DRAIN when drain_req=1; DRAIN->DRAINED when counter=0; DRAINED->RUN when drain_req=0; DRAIN->RUN if drain_req deasserts before empty.
REQ-023 SHALL go RUN->DRAINED directly when drain_req=1 and counter=0 in the same cycle.
REQ-024 SHALL, in DRAIN and DRAINED, hold req_ready=0 while in-flight products still retire on rsp_valid.
REQ-025 SHALL keep requester inputs ignored while req_ready is low; the requester holds req_valid and operands until the transfer.

Reset
REQ-026 SHALL on rst force: req_ready=0, rsp_valid=0, m_a=m_b=0, shift register cleared, counter=0, busy=0, state=RUN, drained=0, priority pointer=0.
REQ-027 SHALL discard all in-flight products on reset mid-operation; no rsp_valid after rst deasserts until a new transfer completes.

Configuration
REQ-028 SHALL use macro MULT_ARB_ROUND_ROBIN_EN: defined -> round-robin; the pointer moves to the grantee+1 (mod NUM_REQ) after each transfer; search starts at the pointer.
REQ-029 SHALL, without MULT_ARB_ROUND_ROBIN_EN, use fixed priority: lowest-index valid requester wins; no pointer state.

Verification
REQ-030 SHALL cover: single req 0, a=-3, b=7, defaults -> rsp_valid=0001, rsp_c=-21 exactly 7 cycles after transfer.
REQ-031 SHALL cover: all 4 valid continuously, RR enabled -> grant order 0,1,2,3,0..., one grant per cycle, responses in the same order.
REQ-032 SHALL cover: same as REQ-031 with RR disabled -> requester 0 granted every cycle, others starved.
REQ-033 SHALL cover: drain_req raised with 3 in flight -> req_ready=0 at once, 3 responses retire, drained=1 the cycle after counter hits 0, busy=0.
REQ-034 SHALL cover: rst pulsed with 5 in flight -> no rsp_valid afterwards, counter=0, state RUN.
REQ-035 SHALL cover: a=b=-2^(DATA_WIDTH-1) -> rsp_c=2^(2*DATA_WIDTH-2).

Source files
------------

// File: rtl/mult_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared pipelined signed multiplier and routes products back.
// Define MULT_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module mult_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_b,
  output logic signed [DATA_WIDTH-1:0]     m_a,
  output logic signed [DATA_WIDTH-1:0]     m_b,
  input  logic signed [2*DATA_WIDTH-1:0]   m_c,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic signed [2*DATA_WIDTH-1:0]   rsp_c,
  input  logic                             drain_req,
  output logic                             drained,
  output logic                             busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MULT_LATENCY + 2);

  typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;

  state_t                               state;
  logic [CNT_W-1:0]                     cnt;
  logic                                 gnt_any;
  logic [IDX_W-1:0]                     gnt_idx;
  logic                                 grant_en;
  logic                                 xfer;
  logic [MULT_LATENCY-1:0]              vld_p;
  logic [MULT_LATENCY-1:0][IDX_W-1:0]   tag_p;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return NUM_REQ'(1) << i;
  endfunction

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + IDX_W'(1);
  endfunction

`ifdef MULT_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr;

  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_any && req_valid[rr_idx(ptr, k)]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_idx(ptr, k);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ptr <= '0;
    else if (xfer) ptr <= wrap_inc(gnt_idx);
  end
`else
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
  end
`endif

  // Raising drain_req blocks grants in the same cycle so nothing new enters while the FSM leaves RUN.
  assign grant_en  = !rst && (state == RUN) && !drain_req;
  assign xfer      = grant_en && gnt_any;
  assign req_ready = xfer ? onehot(gnt_idx) : '0;
  assign rsp_c     = m_c;
  assign busy      = (cnt != '0);
  assign drained   = (state == DRAINED);

  // Stage p0: capture granted operands for the multiplier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a <= '0;
      m_b <= '0;
    end else if (xfer) begin
      m_a <= req_a[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      m_b <= req_b[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Stages p1..pL: tag travels with the product; rsp_valid registered to land with m_c
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p     <= '0;
      tag_p     <= '0;
      rsp_valid <= '0;
    end else begin
      vld_p     <= {vld_p[MULT_LATENCY-2:0], xfer};
      tag_p     <= {tag_p[MULT_LATENCY-2:0], gnt_idx};
      rsp_valid <= vld_p[MULT_LATENCY-1] ? onehot(tag_p[MULT_LATENCY-1]) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case ({xfer, |rsp_valid})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      case (state)
        RUN:     if (drain_req) state <= (cnt == '0) ? DRAINED : DRAIN;
        DRAIN:   if (!drain_req)     state <= RUN;
                 else if (cnt == '0) state <= DRAINED;
        DRAINED: if (!drain_req) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural multiplier and an in-order response scoreboard.
module tb_mult_arbiter;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int ML = 6;

  logic                   clk;
  logic                   rst;
  logic [NR-1:0]          req_valid;
  logic [NR-1:0]          req_ready;
  logic [NR*DW-1:0]       req_a;
  logic [NR*DW-1:0]       req_b;
  logic signed [DW-1:0]   m_a;
  logic signed [DW-1:0]   m_b;
  logic signed [2*DW-1:0] m_c;
  logic [NR-1:0]          rsp_valid;
  logic signed [2*DW-1:0] rsp_c;
  logic                   drain_req;
  logic                   drained;
  logic                   busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    int     idx;
    longint prod;
    int     due;
  } exp_t;
  exp_t sbq[$];

  logic signed [2*DW-1:0] mpipe [ML];

  mult_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MULT_LATENCY(ML)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .m_a(m_a), .m_b(m_b), .m_c(m_c),
    .rsp_valid(rsp_valid), .rsp_c(rsp_c), .drain_req(drain_req),
    .drained(drained), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: product appears ML cycles after operands.
  assign m_c = mpipe[ML-1];
  always @(posedge clk) begin
    mpipe[0] <= m_a * m_b;
    for (int k = 1; k < ML; k++) mpipe[k] <= mpipe[k-1];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint prod_of(input int i);
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] b;
    a = req_a[i*DW +: DW];
    b = req_b[i*DW +: DW];
    return longint'(a) * longint'(b);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
    end else begin
      check_eq("busy_vs_inflight", busy, sbq.size() != 0);
      check_eq("ready_onehot", $countones(req_ready) <= 1, 1);
      for (int i = 0; i < NR; i++)
        if (req_valid[i] && req_ready[i])
          sbq.push_back('{idx: i, prod: prod_of(i), due: cyc + 1 + ML});
      if (rsp_valid != '0) begin
        if (sbq.size() == 0) begin
          check_eq("rsp_unexpected", rsp_valid, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check_eq("rsp_idx", rsp_valid, 4'b0001 << e.idx);
          check_eq("rsp_c", rsp_c, e.prod);
          check_eq("rsp_cycle", cyc, e.due);
        end
      end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
        check_eq("rsp_missing", rsp_valid, 4'b0001 << sbq[0].idx);
        void'(sbq.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req_valid = '0;
    drain_req = 1'b0;
    rst = 1'b1;
    repeat (2) tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic set_ops;
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = 32'(i * 5 - 7);
      req_b[i*DW +: DW] = 32'(3 - i * 11);
    end
  endtask

  task automatic single_xfer(input int idx, input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] exp_c);
    req_a[idx*DW +: DW] = a;
    req_b[idx*DW +: DW] = b;
    req_valid = 4'b0001 << idx;
    #1;
    check_eq("xfer_ready", req_ready, 4'b0001 << idx);
    tick;
    req_valid = '0;
    check_eq("m_a", $unsigned(m_a), a);
    check_eq("m_b", $unsigned(m_b), b);
    check_eq("busy_after_xfer", busy, 1);
    for (int k = 0; k < 5; k++) begin
      tick;
      check_eq("lat_early", rsp_valid, 0);
    end
    tick;
    check_eq("lat_rsp_valid", rsp_valid, 4'b0001 << idx);
    check_eq("lat_rsp_c", rsp_c, exp_c);
    tick;
    check_eq("busy_after_rsp", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drain_req = 1'b0;
    req_valid = 4'hF;
    req_a = '0;
    req_b = '0;
    tick;
    tick;
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_m_a", $unsigned(m_a), 0);
    check_eq("rst_m_b", $unsigned(m_b), 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_drained", drained, 0);
    rst = 1'b0;
    req_valid = '0;
    tick;

    // -3 * 7 = -21
    single_xfer(0, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);

    // All requesters valid continuously
    do_reset;
    set_ops;
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
`ifdef MULT_ARB_ROUND_ROBIN_EN
      check_eq("grant_seq", req_ready, 4'b0001 << (k % 4));
`else
      check_eq("grant_seq", req_ready, 4'b0001);
`endif
      tick;
    end
    req_valid = '0;
    repeat (10) tick;

    // Drain with three products in flight
    do_reset;
    set_ops;
    req_valid = 4'hF;
    for (int r = 0; r < 14; r++) begin
      drain_req = (r >= 3 && r < 13);
      #1;
      if (r < 3) begin
`ifdef MULT_ARB_ROUND_ROBIN_EN
        check_eq("drain_pre_grant", req_ready, 4'b0001 << r);
`else
        check_eq("drain_pre_grant", req_ready, 4'b0001);
`endif
      end else begin
        check_eq("drain_ready", req_ready, 0);
        check_eq("drain_busy", busy, r <= 9);
        check_eq("drain_drained", drained, r >= 11);
      end
      tick;
    end
    #1;
    check_eq("undrain_drained", drained, 0);
`ifdef MULT_ARB_ROUND_ROBIN_EN
    check_eq("undrain_ready", req_ready, 4'b1000);
`else
    check_eq("undrain_ready", req_ready, 4'b0001);
`endif
    tick;
    req_valid = '0;
    repeat (10) tick;

    // Reset with five products in flight
    do_reset;
    set_ops;
    req_valid = 4'hF;
    repeat (5) tick;
    req_valid = '0;
    rst = 1'b1;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_rsp_valid", rsp_valid, 0);
    check_eq("midrst_m_a", $unsigned(m_a), 0);
    tick;
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick;
      check_eq("postrst_rsp_valid", rsp_valid, 0);
      check_eq("postrst_busy", busy, 0);
      check_eq("postrst_drained", drained, 0);
    end
    req_valid = 4'b0001;
    #1;
    check_eq("postrst_run_ready", req_ready, 4'b0001);
    tick;
    req_valid = '0;
    repeat (8) tick;

    // Most-negative operands: (-2^31)^2 = 2^62
    single_xfer(2, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

    repeat (3) tick;
    check_eq("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
